// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline stage with a valid/ready handshake, flush-to-bubble and an
// optional skid register (enable with `define EXE_PIPE_SKID_EN).
module exe_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_alu,
  input  logic [DATA_W-1:0] i_in_rm,
  input  logic [DEST_W-1:0] i_in_dest,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [DATA_W-1:0] o_out_alu,
  output logic [DATA_W-1:0] o_out_rm,
  output logic [DEST_W-1:0] o_out_dest,
  output logic [1:0]        o_occupancy
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rm;
  logic [DEST_W-1:0] r_dest;

  logic w_in_fire;
  logic w_out_fire;

  assign w_out_fire  = r_valid && i_out_ready;
  assign w_in_fire   = i_in_valid && o_in_ready;
  assign o_out_valid = r_valid;
  assign o_out_ctrl  = r_ctrl;
  assign o_out_alu   = r_alu;
  assign o_out_rm    = r_rm;
  assign o_out_dest  = r_dest;

`ifdef EXE_PIPE_SKID_EN
  logic              r_s_valid;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_alu;
  logic [DATA_W-1:0] r_s_rm;
  logic [DEST_W-1:0] r_s_dest;

  // in_ready depends only on registered skid state, breaking the out_ready path
  assign o_in_ready  = !i_flush && !r_s_valid;
  assign o_occupancy = {1'b0, r_valid} + {1'b0, r_s_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_alu     <= '0;
      r_rm      <= '0;
      r_dest    <= '0;
      r_s_valid <= 1'b0;
      r_s_ctrl  <= '0;
      r_s_alu   <= '0;
      r_s_rm    <= '0;
      r_s_dest  <= '0;
    end else if (r_s_valid) begin
      if (w_out_fire) begin
        r_ctrl    <= r_s_ctrl;
        r_alu     <= r_s_alu;
        r_rm      <= r_s_rm;
        r_dest    <= r_s_dest;
        r_s_valid <= 1'b0;
        r_s_ctrl  <= '0;
        r_s_alu   <= '0;
        r_s_rm    <= '0;
        r_s_dest  <= '0;
      end
    end else if (w_in_fire && r_valid && !w_out_fire) begin
      r_s_valid <= 1'b1;
      r_s_ctrl  <= i_in_ctrl;
      r_s_alu   <= i_in_alu;
      r_s_rm    <= i_in_rm;
      r_s_dest  <= i_in_dest;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_in_ctrl;
      r_alu   <= i_in_alu;
      r_rm    <= i_in_rm;
      r_dest  <= i_in_dest;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end
`else
  assign o_in_ready  = !i_flush && (!r_valid || i_out_ready);
  assign o_occupancy = {1'b0, r_valid};

  // Control is zeroed whenever the stage empties so a bubble can never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_alu   <= '0;
      r_rm    <= '0;
      r_dest  <= '0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_in_ctrl;
      r_alu   <= i_in_alu;
      r_rm    <= i_in_rm;
      r_dest  <= i_in_dest;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Directed self-checking bench for exe_mem_pipe_stage; expectations are
// hand-computed for the build mode selected by EXE_PIPE_SKID_EN.
module tb_exe_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  inCtrl = '0;
  logic [31:0] inAlu = '0;
  logic [31:0] inRm = '0;
  logic [3:0]  inDest = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [2:0]  outCtrl;
  logic [31:0] outAlu;
  logic [31:0] outRm;
  logic [3:0]  outDest;
  logic [1:0]  occupancy;

  int nChecks = 0;
  int nPass = 0;
  int nFail = 0;

  exe_mem_pipe_stage #(.DATA_W(32), .DEST_W(4), .CTRL_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .i_flush(flush),
    .i_in_valid(inValid),
    .o_in_ready(inReady),
    .i_in_ctrl(inCtrl),
    .i_in_alu(inAlu),
    .i_in_rm(inRm),
    .i_in_dest(inDest),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_out_ctrl(outCtrl),
    .o_out_alu(outAlu),
    .o_out_rm(outRm),
    .o_out_dest(outDest),
    .o_occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] r, input logic [3:0] d);
    inValid = v;
    inCtrl  = c;
    inAlu   = a;
    inRm    = r;
    inDest  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a beat offered
    applyStimulus(1'b1, 3'b001, 32'h99, 32'h98, 4'h9);
    step();
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_ctrl", outCtrl, 0);
    checkOutput("rst_alu", outAlu, 0);
    checkOutput("rst_occ", occupancy, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_in_ready", inReady, 1);

    // Async reset in mid-cycle discards a held beat
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b001, 32'h55, 32'h66, 4'h3);
    step();
    checkOutput("pre_arst_alu", outAlu, 32'h55);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", outValid, 0);
    checkOutput("arst_alu", outAlu, 0);
    checkOutput("arst_rm", outRm, 0);
    checkOutput("arst_dest", outDest, 0);
    checkOutput("arst_occ", occupancy, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    outReady = 1'b1;
    #1;
    checkOutput("arst_in_ready", inReady, 1);

    // Streaming at full rate
    applyStimulus(1'b1, 3'b001, 32'h10, 32'h1, 4'h1);
    step();
    checkOutput("stream0_alu", outAlu, 32'h10);
    checkOutput("stream0_valid", outValid, 1);
    applyStimulus(1'b1, 3'b001, 32'h20, 32'h2, 4'h2);
    step();
    checkOutput("stream1_alu", outAlu, 32'h20);
    checkOutput("stream1_occ", occupancy, 1);
    applyStimulus(1'b1, 3'b001, 32'h30, 32'h3, 4'h3);
    step();
    checkOutput("stream2_alu", outAlu, 32'h30);
    checkOutput("stream2_valid", outValid, 1);
    applyStimulus(1'b0, 0, 0, 0, 0);
    step();
    checkOutput("stream_drain_valid", outValid, 0);
    checkOutput("stream_drain_ctrl", outCtrl, 0);

    // Stall with beat A held, beat B offered
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b001, 32'hA1, 32'hB1, 4'hA);
    step();
    checkOutput("stallA_valid", outValid, 1);
    checkOutput("stallA_dest", outDest, 4'hA);
    applyStimulus(1'b1, 3'b010, 32'hA2, 32'hB2, 4'hB);
    #1;
`ifdef EXE_PIPE_SKID_EN
    checkOutput("stall_in_ready", inReady, 1);
    step();
    applyStimulus(1'b0, 0, 0, 0, 0);
    #1;
    checkOutput("stall_occ", occupancy, 2);
    checkOutput("stall_full_in_ready", inReady, 0);
    checkOutput("stall_hold_alu", outAlu, 32'hA1);
    checkOutput("stall_hold_ctrl", outCtrl, 3'b001);
    outReady = 1'b1;
    step();
    checkOutput("releaseB_alu", outAlu, 32'hA2);
    checkOutput("releaseB_dest", outDest, 4'hB);
    checkOutput("releaseB_occ", occupancy, 1);
`else
    checkOutput("stall_in_ready", inReady, 0);
    step();
    checkOutput("stall_occ", occupancy, 1);
    checkOutput("stall_hold_alu", outAlu, 32'hA1);
    checkOutput("stall_hold_ctrl", outCtrl, 3'b001);
    outReady = 1'b1;
    step();
    checkOutput("releaseB_alu", outAlu, 32'hA2);
    checkOutput("releaseB_dest", outDest, 4'hB);
    checkOutput("releaseB_ctrl", outCtrl, 3'b010);
    applyStimulus(1'b0, 0, 0, 0, 0);
`endif
    step();
    checkOutput("release_empty_valid", outValid, 0);
    checkOutput("release_empty_occ", occupancy, 0);

    // Flush with beats held and a new beat offered
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b100, 32'hC1, 32'hD1, 4'h5);
    step();
    applyStimulus(1'b1, 3'b001, 32'hC2, 32'hD2, 4'h6);
    step();
`ifdef EXE_PIPE_SKID_EN
    checkOutput("preflush_occ", occupancy, 2);
`else
    checkOutput("preflush_occ", occupancy, 1);
`endif
    flush = 1'b1;
    applyStimulus(1'b1, 3'b001, 32'hC3, 32'hD3, 4'h7);
    #1;
    checkOutput("flush_in_ready", inReady, 0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    #1;
    checkOutput("flush_valid", outValid, 0);
    checkOutput("flush_ctrl", outCtrl, 0);
    checkOutput("flush_occ", occupancy, 0);
    checkOutput("flush_alu", outAlu, 0);
    step();
    checkOutput("flush_no_accept", outValid, 0);

    // Bubble after a single beat drains
    outReady = 1'b1;
    applyStimulus(1'b1, 3'b101, 32'hBEEF, 32'h1234, 4'h7);
    step();
    checkOutput("bubble_beat_ctrl", outCtrl, 3'b101);
    applyStimulus(1'b0, 0, 0, 0, 0);
    step();
    checkOutput("bubble_valid", outValid, 0);
    checkOutput("bubble_ctrl", outCtrl, 0);
    checkOutput("bubble_alu_hold", outAlu, 32'hBEEF);
    checkOutput("bubble_dest_hold", outDest, 4'h7);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
